// File: rtl/debug_cmd_master.sv
// rtl/debug_cmd_master.sv - UART byte stream to debug bus register access master
//
// Purpose:
//   Decodes read frames (01, addr) and write frames (02, addr, dlo, dhi)
//   from the debug UART receiver. Each frame becomes one 16-bit access on
//   the debug bus. The block then answers the UART transmitter with a
//   status byte, followed by the read data for a successful read.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   rx_data, rx_valid  received byte, one-cycle valid pulse
//   tx_data, tx_valid  byte to transmit, held until tx_ready
//   tx_ready           transmitter accepts on tx_valid && tx_ready
//   dbg_a, dbg_di      bus address and write data (registered, stable during strobe)
//   dbg_do             bus read data
//   dbg_we, dbg_rd     write / read strobes (mutually exclusive)
//   dbg_ready          access complete (may depend combinationally on the strobes)
//   busy               high whenever the FSM is not idle
//   rx_drop            one-cycle pulse when a byte arrives while on the bus or responding

module debug_cmd_master #(
    parameter int         BUS_TIMEOUT = 256,
    parameter int         RX_TIMEOUT  = 50000,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter logic [7:0] NAK_BYTE    = 8'h15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  dbg_a,
    output logic [15:0] dbg_di,
    input  logic [15:0] dbg_do,
    output logic        dbg_we,
    output logic        dbg_rd,
    input  logic        dbg_ready,
    output logic        busy,
    output logic        rx_drop
);

    localparam int BCW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam int RCW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
    localparam logic [BCW-1:0] BUS_LAST = BCW'(BUS_TIMEOUT - 1);
    localparam logic [RCW-1:0] RX_LAST  = RCW'(RX_TIMEOUT - 1);

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DLO,
        S_GET_DHI,
        S_BUS,
        S_RESP_STAT,
        S_RESP_LO,
        S_RESP_HI
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic           r_op_wr;     // 1 = write frame, 0 = read frame
    logic           r_ok;        // status of the last access: ACK when set, NAK otherwise
    logic [7:0]     r_addr;
    logic [15:0]    r_wdata;
    logic [15:0]    r_rdata;
    logic [BCW-1:0] r_bus_cnt;
    logic [RCW-1:0] r_rx_cnt;

    logic           w_in_get;
    logic           w_in_bus;
    logic           w_in_resp;
    logic           w_rx_to;
    logic           w_bus_to;
    logic           w_tx_fire;

    always_comb begin
        w_in_get  = (r_state == S_GET_ADDR) || (r_state == S_GET_DLO) || (r_state == S_GET_DHI);
        w_in_bus  = (r_state == S_BUS);
        w_in_resp = (r_state == S_RESP_STAT) || (r_state == S_RESP_LO) || (r_state == S_RESP_HI);
        w_rx_to   = w_in_get && !rx_valid && (r_rx_cnt == RX_LAST);
        // dbg_ready wins over the timeout on the final allowed cycle.
        w_bus_to  = w_in_bus && !dbg_ready && (r_bus_cnt == BUS_LAST);
        w_tx_fire = w_in_resp && tx_ready;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == OP_READ) || (rx_data == OP_WRITE)) begin
                        w_state_next = S_GET_ADDR;
                    end else begin
                        w_state_next = S_RESP_STAT;
                    end
                end
            end
            S_GET_ADDR: begin
                if (rx_valid) begin
                    w_state_next = r_op_wr ? S_GET_DLO : S_BUS;
                end else if (w_rx_to) begin
                    w_state_next = S_IDLE;
                end
            end
            S_GET_DLO: begin
                if (rx_valid) begin
                    w_state_next = S_GET_DHI;
                end else if (w_rx_to) begin
                    w_state_next = S_IDLE;
                end
            end
            S_GET_DHI: begin
                if (rx_valid) begin
                    w_state_next = S_BUS;
                end else if (w_rx_to) begin
                    w_state_next = S_IDLE;
                end
            end
            S_BUS: begin
                if (dbg_ready || w_bus_to) begin
                    w_state_next = S_RESP_STAT;
                end
            end
            S_RESP_STAT: begin
                if (w_tx_fire) begin
                    w_state_next = (r_ok && !r_op_wr) ? S_RESP_LO : S_IDLE;
                end
            end
            S_RESP_LO: begin
                if (w_tx_fire) begin
                    w_state_next = S_RESP_HI;
                end
            end
            S_RESP_HI: begin
                if (w_tx_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state so the asynchronous reset
    // drops strobes and tx_valid without waiting for a clock edge.
    always_comb begin
        dbg_rd   = w_in_bus && !r_op_wr;
        dbg_we   = w_in_bus && r_op_wr;
        dbg_a    = r_addr;
        dbg_di   = r_wdata;
        busy     = (r_state != S_IDLE);
        rx_drop  = rx_valid && (w_in_bus || w_in_resp);
        tx_valid = w_in_resp;
        tx_data  = 8'h00;
        case (r_state)
            S_RESP_STAT: tx_data = r_ok ? ACK_BYTE : NAK_BYTE;
            S_RESP_LO:   tx_data = r_rdata[7:0];
            S_RESP_HI:   tx_data = r_rdata[15:8];
            default:     tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame capture, bus result capture and timeout counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_wr   <= 1'b0;
            r_ok      <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 16'h0000;
            r_rdata   <= 16'h0000;
            r_bus_cnt <= '0;
            r_rx_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        if ((rx_data == OP_READ) || (rx_data == OP_WRITE)) begin
                            r_op_wr <= (rx_data == OP_WRITE);
                        end else begin
                            r_op_wr <= 1'b0;
                            r_ok    <= 1'b0;
                        end
                    end
                end
                S_GET_ADDR: if (rx_valid) r_addr        <= rx_data;
                S_GET_DLO:  if (rx_valid) r_wdata[7:0]  <= rx_data;
                S_GET_DHI:  if (rx_valid) r_wdata[15:8] <= rx_data;
                S_BUS: begin
                    if (dbg_ready) begin
                        r_ok <= 1'b1;
                        if (!r_op_wr) begin
                            r_rdata <= dbg_do;
                        end
                    end else if (w_bus_to) begin
                        r_ok <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (w_in_bus && (w_state_next == S_BUS)) begin
                r_bus_cnt <= r_bus_cnt + 1'b1;
            end else begin
                r_bus_cnt <= '0;
            end

            // Any accepted byte restarts the inter-byte window.
            if (w_in_get && !rx_valid && !w_rx_to) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end else begin
                r_rx_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_debug_cmd_master.sv
// tb/tb_debug_cmd_master.sv - directed self-checking bench for debug_cmd_master

module tb_debug_cmd_master;

    localparam int TB_BUS_TO = 40;
    localparam int TB_RX_TO  = 300;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  dbg_a;
    logic [15:0] dbg_di;
    logic [15:0] dbg_do;
    logic        dbg_we;
    logic        dbg_rd;
    logic        dbg_ready;
    logic        busy;
    logic        rx_drop;

    int total = 0;
    int bad   = 0;

    // slave model
    logic slave_en;
    int   slave_wait;
    int   wait_cnt;

    // monitor state
    int         rd_cycles  = 0;
    int         we_cycles  = 0;
    int         drops      = 0;
    int         stab_err   = 0;
    int         clash      = 0;
    logic [7:0] last_we_a  = 8'h00;
    logic [15:0] last_we_di = 16'h0000;
    logic [7:0] last_rd_a  = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] tx_log[$];

    debug_cmd_master #(
        .BUS_TIMEOUT (TB_BUS_TO),
        .RX_TIMEOUT  (TB_RX_TO),
        .ACK_BYTE    (8'h06),
        .NAK_BYTE    (8'h15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dbg_a     (dbg_a),
        .dbg_di    (dbg_di),
        .dbg_do    (dbg_do),
        .dbg_we    (dbg_we),
        .dbg_rd    (dbg_rd),
        .dbg_ready (dbg_ready),
        .busy      (busy),
        .rx_drop   (rx_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dbg_ready = slave_en && (dbg_rd || dbg_we) && (wait_cnt >= slave_wait);

    always @(posedge clk) begin
        if (dbg_rd || dbg_we) wait_cnt <= wait_cnt + 1;
        else                  wait_cnt <= 0;
    end

    always @(negedge clk) begin
        if (dbg_rd) begin
            rd_cycles = rd_cycles + 1;
            last_rd_a = dbg_a;
        end
        if (dbg_we) begin
            we_cycles  = we_cycles + 1;
            last_we_a  = dbg_a;
            last_we_di = dbg_di;
        end
        if (dbg_rd && dbg_we) clash = clash + 1;
        if (rx_drop) drops = drops + 1;
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (prev_valid && !prev_ready && rst_n && (!tx_valid || tx_data != prev_data))
            stab_err = stab_err + 1;
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s idle_wait: busy=%0b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic check_tx(input string name, input int base, input logic [7:0] exp[$]);
        total++;
        if (tx_log.size() - base != exp.size()) begin
            bad++;
            $display("FAIL %s tx_count: got %0d, required %0d", name, tx_log.size() - base, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                total++;
                if (tx_log[base + i] !== exp[i]) begin
                    bad++;
                    $display("FAIL %s tx_byte%0d: got %02h, required %02h", name, i, tx_log[base + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        slave_en = 1'b1; slave_wait = 0; dbg_do = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({tx_valid, dbg_we, dbg_rd, busy, rx_drop} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %05b, required 00000", {tx_valid, dbg_we, dbg_rd, busy, rx_drop});
        end
        total++;
        if ({tx_data, dbg_a, dbg_di} !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got %08h, required 00000000", {tx_data, dbg_a, dbg_di});
        end
    endtask

    task automatic test_write();
        int b0, w0, r0;
        b0 = tx_log.size(); w0 = we_cycles; r0 = rd_cycles;
        slave_en = 1'b1; slave_wait = 0;
        send_byte(8'h02); send_byte(8'h13); send_byte(8'h34); send_byte(8'h12);
        wait_idle(100, "write");
        total++;
        if (we_cycles - w0 != 1) begin
            bad++; $display("FAIL write_we_cycles: got %0d, required 1", we_cycles - w0);
        end
        total++;
        if (rd_cycles - r0 != 0) begin
            bad++; $display("FAIL write_rd_cycles: got %0d, required 0", rd_cycles - r0);
        end
        total++;
        if (last_we_a !== 8'h13 || last_we_di !== 16'h1234) begin
            bad++; $display("FAIL write_addr_data: got %02h/%04h, required 13/1234", last_we_a, last_we_di);
        end
        check_tx("write", b0, '{8'h06});
    endtask

    task automatic test_read();
        int b0, r0;
        b0 = tx_log.size(); r0 = rd_cycles;
        slave_en = 1'b1; slave_wait = 3; dbg_do = 16'hBEEF;
        send_byte(8'h01); send_byte(8'h1B);
        wait_idle(100, "read");
        total++;
        if (rd_cycles - r0 != 4) begin
            bad++; $display("FAIL read_rd_cycles: got %0d, required 4", rd_cycles - r0);
        end
        total++;
        if (last_rd_a !== 8'h1B) begin
            bad++; $display("FAIL read_addr: got %02h, required 1b", last_rd_a);
        end
        check_tx("read", b0, '{8'h06, 8'hEF, 8'hBE});
        slave_wait = 0;
    endtask

    task automatic test_bus_timeout();
        int b0, r0;
        b0 = tx_log.size(); r0 = rd_cycles;
        slave_en = 1'b0;
        send_byte(8'h01); send_byte(8'h20);
        wait_idle(TB_BUS_TO + 50, "bus_timeout");
        total++;
        if (rd_cycles - r0 != TB_BUS_TO) begin
            bad++; $display("FAIL bus_timeout_rd_cycles: got %0d, required %0d", rd_cycles - r0, TB_BUS_TO);
        end
        check_tx("bus_timeout", b0, '{8'h15});
        slave_en = 1'b1;
    endtask

    task automatic test_bad_opcode_and_rx_timeout();
        int b0, w0, r0;
        b0 = tx_log.size();
        send_byte(8'h7F);
        wait_idle(50, "bad_opcode");
        check_tx("bad_opcode", b0, '{8'h15});

        b0 = tx_log.size(); w0 = we_cycles;
        send_byte(8'h02); send_byte(8'h10);
        repeat (TB_RX_TO - 1) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL rx_timeout_early: busy=%0b, required 1", busy);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rx_timeout_expire: busy=%0b, required 0", busy);
        end
        total++;
        if (we_cycles - w0 != 0) begin
            bad++; $display("FAIL rx_timeout_we: got %0d, required 0", we_cycles - w0);
        end
        check_tx("rx_timeout", b0, '{});

        b0 = tx_log.size(); r0 = rd_cycles;
        dbg_do = 16'h5A3C;
        send_byte(8'h01); send_byte(8'h10);
        wait_idle(100, "after_timeout");
        total++;
        if (rd_cycles - r0 != 1 || last_rd_a !== 8'h10) begin
            bad++; $display("FAIL after_timeout_read: got %0d cycles addr %02h, required 1 cycle addr 10", rd_cycles - r0, last_rd_a);
        end
        check_tx("after_timeout", b0, '{8'h06, 8'h3C, 8'h5A});
    endtask

    task automatic test_backpressure();
        int b0, s0, d0, n;
        b0 = tx_log.size(); s0 = stab_err; d0 = drops;
        dbg_do = 16'hC3A5; slave_wait = 0;
        tx_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h22);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!tx_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (!tx_valid) begin
                bad++; $display("FAIL bp_tx_valid%0d: got 0, required 1", k);
            end
            if (k == 1) begin
                @(posedge clk); #1;
                rx_data = 8'h55; rx_valid = 1'b1;
                @(negedge clk);
                total++;
                if (rx_drop !== 1'b1) begin
                    bad++; $display("FAIL bp_rx_drop: got %0b, required 1", rx_drop);
                end
                @(posedge clk); #1;
                rx_valid = 1'b0;
                @(negedge clk);
                total++;
                if (rx_drop !== 1'b0 || tx_data !== 8'hA5) begin
                    bad++; $display("FAIL bp_after_drop: rx_drop=%0b tx_data=%02h, required 0/a5", rx_drop, tx_data);
                end
            end
            repeat (10) @(posedge clk);
            #1 tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
        end
        tx_ready = 1'b1;
        wait_idle(50, "backpressure");
        total++;
        if (stab_err - s0 != 0) begin
            bad++; $display("FAIL bp_stability: got %0d violations, required 0", stab_err - s0);
        end
        total++;
        if (drops - d0 != 1) begin
            bad++; $display("FAIL bp_drop_count: got %0d, required 1", drops - d0);
        end
        check_tx("backpressure", b0, '{8'h06, 8'hA5, 8'hC3});
    endtask

    task automatic test_back_to_back();
        int b0, r0, d0;
        b0 = tx_log.size(); r0 = rd_cycles; d0 = drops;
        dbg_do = 16'h0F0F;
        send_byte(8'h7F); send_byte(8'h01); send_byte(8'h44);
        wait_idle(100, "back_to_back");
        total++;
        if (rd_cycles - r0 != 1 || last_rd_a !== 8'h44 || drops - d0 != 0) begin
            bad++; $display("FAIL b2b_read: got %0d cycles addr %02h drops %0d, required 1/44/0", rd_cycles - r0, last_rd_a, drops - d0);
        end
        check_tx("back_to_back", b0, '{8'h15, 8'h06, 8'h0F, 8'h0F});
        total++;
        if (clash != 0) begin
            bad++; $display("FAIL strobe_clash: got %0d, required 0", clash);
        end
    endtask

    task automatic test_async_reset();
        slave_en = 1'b0;
        send_byte(8'h01); send_byte(8'h30);
        @(negedge clk);
        total++;
        if (dbg_rd !== 1'b1) begin
            bad++; $display("FAIL areset_pre: dbg_rd=%0b, required 1", dbg_rd);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({dbg_rd, tx_valid, busy} !== 3'b000) begin
            bad++; $display("FAIL areset_ctrl: got %03b, required 000", {dbg_rd, tx_valid, busy});
        end
        total++;
        if (dbg_a !== 8'h00) begin
            bad++; $display("FAIL areset_addr: got %02h, required 00", dbg_a);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        slave_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bus_timeout();
        test_bad_opcode_and_rx_timeout();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
